// File: rtl/head_table_upd_pkg.sv
// Shared types for the head-pointer table update path: request record and FSM states.
package head_table_upd_pkg;

  localparam int BUCKET_WIDTH   = 8;
  localparam int HEAD_PTR_WIDTH = 8;

  typedef struct packed {
    logic [BUCKET_WIDTH-1:0]   bucket;
    logic [HEAD_PTR_WIDTH-1:0] ptr;
    logic                      ptr_val;
  } head_upd_req_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_CLEAR_START = 2'd1,
    ST_CLEAR_WAIT  = 2'd2
  } upd_state_e;

endpackage

// File: rtl/head_table_if.sv
// Write port into the head-pointer RAM; exactly one master drives it.
interface head_table_if;
  import head_table_upd_pkg::*;

  logic [BUCKET_WIDTH-1:0]   wr_addr;
  logic [HEAD_PTR_WIDTH-1:0] wr_data_ptr;
  logic                      wr_data_ptr_val;
  logic                      wr_en;

  modport master (output wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en);
  modport slave  (input  wr_addr, wr_data_ptr, wr_data_ptr_val, wr_en);
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // last_q = 1 means port 1 won the most recent grant; port 0 wins the first tie
  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)               last_q <= 1'b1;
    else if (en && |gnt)     last_q <= gnt[1];
  end

endmodule

// File: rtl/head_table_upd.sv
// Single writer of head-pointer RAM updates: arbitrates insert/delete engines and owns RAM clear.
module head_table_upd
  import head_table_upd_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  head_upd_req_t        ins_req_i,
  input  logic                 ins_valid_i,
  output logic                 ins_ready_o,
  input  head_upd_req_t        del_req_i,
  input  logic                 del_valid_i,
  output logic                 del_ready_o,
  head_table_if.master         head_table,
  input  logic                 clear_req_i,
  output logic                 clear_ram_run_o,
  input  logic                 clear_ram_done_i,
  output logic                 clear_busy_o,
  output logic [CNT_WIDTH-1:0] wr_cnt_o
);

  upd_state_e    state_q;
  head_upd_req_t wr_q;
  head_upd_req_t wr_sel;
  logic          wr_en_q;
  logic          idle_ok;
  logic [1:0]    gnt;
  logic          ins_acc;
  logic          del_acc;
  logic          acc;

  assign idle_ok = (state_q == ST_IDLE) && !rst_i;

  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req   ({del_valid_i, ins_valid_i}),
    .en    (idle_ok),
    .gnt   (gnt)
  );

  // A port only loses its ready when both compete and the other side holds the grant
  assign ins_ready_o  = idle_ok && !(ins_valid_i && del_valid_i && gnt[1]);
  assign del_ready_o  = idle_ok && !(ins_valid_i && del_valid_i && gnt[0]);
  assign ins_acc      = ins_valid_i && ins_ready_o;
  assign del_acc      = del_valid_i && del_ready_o;
  assign acc          = ins_acc || del_acc;
  assign wr_sel       = ins_acc ? ins_req_i : del_req_i;
  assign clear_busy_o = (state_q != ST_IDLE) || (idle_ok && clear_req_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= CLEAR_ON_RESET ? ST_CLEAR_START : ST_IDLE;
      wr_q            <= '0;
      wr_en_q         <= 1'b0;
      clear_ram_run_o <= 1'b0;
      wr_cnt_o        <= '0;
    end else begin
      wr_en_q         <= acc;
      clear_ram_run_o <= 1'b0;
      wr_cnt_o        <= wr_cnt_o + CNT_WIDTH'(acc);
      if (acc) wr_q <= wr_sel;
      // Any write accepted alongside a clear request commits while in CLEAR_START,
      // so the clear pulse always lands on a cycle with no commit.
      case (state_q)
        ST_IDLE: begin
          if (clear_req_i) state_q <= ST_CLEAR_START;
        end
        ST_CLEAR_START: begin
          clear_ram_run_o <= 1'b1;
          state_q         <= ST_CLEAR_WAIT;
        end
        ST_CLEAR_WAIT: begin
          if (clear_ram_done_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign head_table.wr_en           = wr_en_q;
  assign head_table.wr_addr         = wr_q.bucket;
  assign head_table.wr_data_ptr     = wr_q.ptr;
  assign head_table.wr_data_ptr_val = wr_q.ptr_val;

endmodule

// File: tb/tb_head_table_upd.sv
// Self-checking bench for head_table_upd: vector table for arbitration, scoreboard for writes.
module tb_head_table_upd;
  import head_table_upd_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  head_upd_req_t ins_req, del_req;
  logic          ins_v, del_v, clr, done;
  logic          ins_rdy, del_rdy, run, busy;
  logic [31:0]   cnt;
  head_table_if  ht ();

  head_table_upd #(.CLEAR_ON_RESET(1'b1), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .ins_req_i(ins_req), .ins_valid_i(ins_v), .ins_ready_o(ins_rdy),
    .del_req_i(del_req), .del_valid_i(del_v), .del_ready_o(del_rdy),
    .head_table(ht),
    .clear_req_i(clr), .clear_ram_run_o(run), .clear_ram_done_i(done),
    .clear_busy_o(busy), .wr_cnt_o(cnt)
  );

  // Second instance: no clear on reset, narrow counter for wrap-around
  logic          rst2, ins_v2;
  head_upd_req_t ins_req2;
  logic          ins_rdy2, del_rdy2, run2, busy2;
  logic [2:0]    cnt2;
  head_table_if  ht2 ();

  head_table_upd #(.CLEAR_ON_RESET(1'b0), .CNT_WIDTH(3)) dut2 (
    .clk_i(clk), .rst_i(rst2),
    .ins_req_i(ins_req2), .ins_valid_i(ins_v2), .ins_ready_o(ins_rdy2),
    .del_req_i('0), .del_valid_i(1'b0), .del_ready_o(del_rdy2),
    .head_table(ht2),
    .clear_req_i(1'b0), .clear_ram_run_o(run2), .clear_ram_done_i(1'b0),
    .clear_busy_o(busy2), .wr_cnt_o(cnt2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic head_upd_req_t mk(logic [7:0] b, logic [7:0] p, logic v);
    head_upd_req_t r;
    r.bucket = b; r.ptr = p; r.ptr_val = v;
    return r;
  endfunction

  // Scoreboard: stimulus pushes predicted writes; monitor pops one per wr_en
  head_upd_req_t exp_q[$];
  logic          wr_pend   = 1'b0;
  logic [31:0]   model_cnt = '0;

  always @(posedge clk) begin
    head_upd_req_t e;
    #1;
    chk("wr_en", ht.wr_en, wr_pend);
    if (ht.wr_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      model_cnt = model_cnt + 1;
      chk("wr_addr", ht.wr_addr, e.bucket);
      chk("wr_data_ptr", ht.wr_data_ptr, e.ptr);
      chk("wr_data_ptr_val", ht.wr_data_ptr_val, e.ptr_val);
      chk("wr_cnt", cnt, model_cnt);
    end
    wr_pend = 1'b0;
    if (rst) model_cnt = '0;
  end

  typedef struct {
    logic          iv;
    head_upd_req_t ir;
    logic          dv;
    head_upd_req_t dr;
    logic          eir;
    logic          edr;
  } vec_t;

  vec_t vecs[12];

  task automatic expect_accept(head_upd_req_t r);
    exp_q.push_back(r);
    wr_pend = 1'b1;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_wr_en"}, ht.wr_en, 0);
    chk({tag, "_wr_addr"}, ht.wr_addr, 0);
    chk({tag, "_wr_ptr"}, ht.wr_data_ptr, 0);
    chk({tag, "_wr_val"}, ht.wr_data_ptr_val, 0);
    chk({tag, "_run"}, run, 0);
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_rdy"}, {ins_rdy, del_rdy}, 0);
    chk({tag, "_busy"}, busy, 1);
  endtask

  initial begin
    int bad;
    vecs[0]  = '{1'b1, mk(8'h05, 8'h12, 1'b1), 1'b0, mk(8'h00, 8'h00, 1'b0), 1'b1, 1'b1};
    vecs[1]  = '{1'b0, mk(8'h00, 8'h00, 1'b0), 1'b0, mk(8'h00, 8'h00, 1'b0), 1'b1, 1'b1};
    vecs[2]  = '{1'b0, mk(8'h00, 8'h00, 1'b0), 1'b1, mk(8'h20, 8'h21, 1'b1), 1'b1, 1'b1};
    vecs[3]  = '{1'b1, mk(8'h30, 8'h01, 1'b1), 1'b1, mk(8'h40, 8'h02, 1'b0), 1'b1, 1'b0};
    vecs[4]  = '{1'b1, mk(8'h31, 8'h03, 1'b1), 1'b1, mk(8'h41, 8'h04, 1'b0), 1'b0, 1'b1};
    vecs[5]  = '{1'b1, mk(8'h32, 8'h05, 1'b1), 1'b1, mk(8'h42, 8'h06, 1'b0), 1'b1, 1'b0};
    vecs[6]  = '{1'b1, mk(8'h33, 8'h07, 1'b1), 1'b1, mk(8'h43, 8'h08, 1'b0), 1'b0, 1'b1};
    vecs[7]  = '{1'b1, mk(8'h34, 8'h09, 1'b1), 1'b1, mk(8'h44, 8'h0a, 1'b0), 1'b1, 1'b0};
    vecs[8]  = '{1'b1, mk(8'h35, 8'h0b, 1'b1), 1'b1, mk(8'h45, 8'h0c, 1'b0), 1'b0, 1'b1};
    vecs[9]  = '{1'b1, mk(8'h07, 8'h33, 1'b1), 1'b0, mk(8'h00, 8'h00, 1'b0), 1'b1, 1'b1};
    vecs[10] = '{1'b0, mk(8'h00, 8'h00, 1'b0), 1'b1, mk(8'h07, 8'h00, 1'b0), 1'b1, 1'b1};
    vecs[11] = '{1'b0, mk(8'h00, 8'h00, 1'b0), 1'b0, mk(8'h00, 8'h00, 1'b0), 1'b1, 1'b1};

    rst = 1'b1; rst2 = 1'b1;
    ins_v = 1'b0; del_v = 1'b0; clr = 1'b0; done = 1'b0;
    ins_req = '0; del_req = '0; ins_v2 = 1'b0; ins_req2 = mk(8'h11, 8'h22, 1'b1);

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Automatic clear after reset release: one-cycle run pulse, readys held low
    @(negedge clk); #1;
    chk("por_run_pulse", run, 1);
    chk("por_rdy", {ins_rdy, del_rdy}, 0);
    ins_v = 1'b1; ins_req = mk(8'h01, 8'h01, 1'b1);
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); #1;
      if (run !== 1'b0 || ins_rdy !== 1'b0 || del_rdy !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("clear_wait_hold", bad, 0);
    ins_v = 1'b0;
    @(negedge clk); done = 1'b1; #1;
    chk("rdy_before_done", ins_rdy, 0);
    @(negedge clk); done = 1'b0; #1;
    chk("rdy_after_done", {ins_rdy, del_rdy}, 2'b11);
    chk("busy_after_done", busy, 0);

    // Stray done in IDLE has no effect
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0; #1;
    chk("stray_done_busy", busy, 0);
    chk("stray_done_run", run, 0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ins_v = vecs[i].iv; ins_req = vecs[i].ir;
      del_v = vecs[i].dv; del_req = vecs[i].dr;
      #1;
      chk($sformatf("vec%0d_ins_rdy", i), ins_rdy, vecs[i].eir);
      chk($sformatf("vec%0d_del_rdy", i), del_rdy, vecs[i].edr);
      if (vecs[i].iv && vecs[i].eir) expect_accept(vecs[i].ir);
      else if (vecs[i].dv && vecs[i].edr) expect_accept(vecs[i].dr);
    end
    @(negedge clk);
    ins_v = 1'b0; del_v = 1'b0; #1;
    chk("wr_cnt_after_table", cnt, 10);

    // Clear request coinciding with an accepted insert
    @(negedge clk);
    ins_v = 1'b1; ins_req = mk(8'h0a, 8'h44, 1'b1); clr = 1'b1; #1;
    chk("clr_acc_ins_rdy", ins_rdy, 1);
    chk("clr_acc_busy", busy, 1);
    expect_accept(ins_req);
    @(negedge clk); clr = 1'b0; #1;
    chk("clr_start_rdy", {ins_rdy, del_rdy}, 0);
    chk("clr_start_run", run, 0);
    chk("clr_start_busy", busy, 1);
    @(negedge clk); #1;
    chk("clr_run_pulse", run, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (run !== 1'b0 || ins_rdy !== 1'b0 || busy !== 1'b1) bad++;
    end
    chk("clr_wait_hold", bad, 0);

    // Reset during CLEAR_WAIT with an insert still pending
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    chk_reset_outputs("midrst");
    rst = 1'b0; ins_v = 1'b0;
    @(negedge clk); #1;
    chk("midrst_run_pulse", run, 1);
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0; #1;
    chk("midrst_idle_rdy", ins_rdy, 1);
    @(negedge clk);
    ins_v = 1'b1; ins_req = mk(8'h33, 8'h55, 1'b1); #1;
    chk("post_rst_ins_rdy", ins_rdy, 1);
    expect_accept(ins_req);
    @(negedge clk); ins_v = 1'b0; #1;
    chk("post_rst_cnt", cnt, 1);

    // Instance without clear-on-reset: idle straight after reset, counter wraps
    @(negedge clk); #1;
    chk("nc_reset_busy", busy2, 0);
    chk("nc_reset_cnt", cnt2, 0);
    chk("nc_reset_rdy", ins_rdy2, 0);
    rst2 = 1'b0;
    @(negedge clk); #1;
    chk("nc_idle_rdy", ins_rdy2, 1);
    chk("nc_idle_run", run2, 0);
    ins_v2 = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); #1;
      chk($sformatf("nc_cnt_%0d", k), cnt2, 64'(k % 8));
    end
    ins_v2 = 1'b0;

    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
